// File: rtl/mult_acc.sv
// Block accumulator: sums LEN unsigned 32-bit products into an ACC_W-bit register.
// It flags carry-out as a sticky OVF and holds the result until downstream takes it.
module mult_acc #(
  parameter int ACC_W = 48,
  parameter int LEN_W = 8
) (
  input  logic             CLK,
  input  logic             SCLR,
  input  logic             START,
  input  logic [LEN_W-1:0] LEN,
  input  logic [31:0]      P,
  input  logic             P_VALID,
  output logic             P_READY,
  output logic [ACC_W-1:0] ACC,
  output logic             OVF,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic             BUSY
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [ACC_W:0]     sum;
  logic [LEN_W:0]     cnt_inc;

  // Top bit of the result is the carry out of the accumulator width.
  function automatic logic [ACC_W:0] acc_add(input logic [ACC_W-1:0] a,
                                             input logic [31:0]      p);
    return {1'b0, a} + {{(ACC_W+1-32){1'b0}}, p};
  endfunction

  assign sum     = acc_add(acc_q, P);
  assign cnt_inc = {1'b0, cnt_q} + {{LEN_W{1'b0}}, 1'b1};

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    P_READY   = 1'b0;
    OUT_VALID = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          acc_d = '0;
          ovf_d = 1'b0;
          if (LEN != '0) begin
            len_d   = LEN;
            cnt_d   = '0;
            state_d = S_ACCUM;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_ACCUM: begin
        P_READY = 1'b1;
        if (P_VALID) begin
          acc_d = sum[ACC_W-1:0];
          if (sum[ACC_W]) ovf_d = 1'b1;
          cnt_d = cnt_inc[LEN_W-1:0];
          // Extended compare keeps LEN = 2^LEN_W-1 free of wrap.
          if (cnt_inc == {1'b0, len_q}) state_d = S_DONE;
        end
      end
      S_DONE: begin
        OUT_VALID = 1'b1;
        if (OUT_READY) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (SCLR) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

  assign ACC  = acc_q;
  assign OVF  = ovf_q;
  assign BUSY = (state_q != S_IDLE);

endmodule

// File: tb/tb_mult_acc.sv
// Directed bench for mult_acc: a 48-bit instance and a 33-bit instance share all inputs.
// The 33-bit instance exercises accumulator wrap and the sticky overflow flag.
module tb_mult_acc;

  logic        clk = 1'b0;
  logic        sclr, start, p_valid, out_ready;
  logic [7:0]  len;
  logic [31:0] p;

  logic        p_ready48, ovf48, out_valid48, busy48;
  logic [47:0] acc48;
  logic        p_ready33, ovf33, out_valid33, busy33;
  logic [32:0] acc33;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mult_acc #(.ACC_W(48), .LEN_W(8)) u_dut (
    .CLK(clk), .SCLR(sclr), .START(start), .LEN(len), .P(p), .P_VALID(p_valid),
    .P_READY(p_ready48), .ACC(acc48), .OVF(ovf48), .OUT_VALID(out_valid48),
    .OUT_READY(out_ready), .BUSY(busy48)
  );

  mult_acc #(.ACC_W(33), .LEN_W(8)) u_dut33 (
    .CLK(clk), .SCLR(sclr), .START(start), .LEN(len), .P(p), .P_VALID(p_valid),
    .P_READY(p_ready33), .ACC(acc33), .OVF(ovf33), .OUT_VALID(out_valid33),
    .OUT_READY(out_ready), .BUSY(busy33)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_block(input logic [7:0] n);
    start = 1'b1;
    len   = n;
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input logic [31:0] val);
    check("beat_rdy", p_ready48, 1'b1);
    p_valid = 1'b1;
    p       = val;
    tick();
    p_valid = 1'b0;
  endtask

  task automatic gap(input int n, input logic [63:0] acc_exp);
    for (int i = 0; i < n; i++) begin
      check("gap_rdy", p_ready48, 1'b1);
      p = 32'hDEAD_BEEF;
      tick();
      check("gap_acc", acc48, acc_exp);
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    sclr = 1'b1; start = 1'b0; p_valid = 1'b0; out_ready = 1'b0; len = '0; p = '0;
    tick();
    tick();
    sclr = 1'b0;
    check("rst_ready", p_ready48, 1'b0);
    check("rst_ovalid", out_valid48, 1'b0);
    check("rst_busy", busy48, 1'b0);
    check("rst_acc", acc48, 48'h0);
    check("rst_ovf", ovf48, 1'b0);

    // Three back-to-back beats.
    begin_block(8'd3);
    check("b3_busy", busy48, 1'b1);
    check("b3_acc0", acc48, 48'h0);
    beat(32'd5);
    check("b3_acc1", acc48, 48'd5);
    beat(32'd7);
    beat(32'd11);
    check("b3_ovalid", out_valid48, 1'b1);
    check("b3_acc", acc48, 48'd23);
    check("b3_acc33", acc33, 33'd23);
    check("b3_ovf", ovf48, 1'b0);
    check("b3_pready_done", p_ready48, 1'b0);
    release_result();
    check("b3_idle_ovalid", out_valid48, 1'b0);
    check("b3_idle_busy", busy48, 1'b0);
    check("b3_idle_acc", acc48, 48'd23);

    // Bubbles between beats: gaps of 0, 2, 1 cycles.
    begin_block(8'd4);
    beat(32'd1);
    beat(32'd1);
    gap(2, 64'd2);
    beat(32'd1);
    gap(1, 64'd3);
    check("gap_notdone", out_valid48, 1'b0);
    beat(32'd1);
    check("gap_ovalid", out_valid48, 1'b1);
    check("gap_acc", acc48, 48'd4);
    release_result();

    // Wrap in the 33-bit instance; the 48-bit one just carries on.
    begin_block(8'd3);
    beat(32'hFFFF_FFFF);
    beat(32'hFFFF_FFFF);
    beat(32'hFFFF_FFFF);
    check("wrap_ovalid", out_valid33, 1'b1);
    check("wrap_acc33", acc33, 33'h0_FFFF_FFFD);
    check("wrap_ovf33", ovf33, 1'b1);
    check("wrap_acc48", acc48, 48'h2_FFFF_FFFD);
    check("wrap_ovf48", ovf48, 1'b0);
    release_result();
    check("wrap_ovf_hold", ovf33, 1'b1);

    // Empty block: straight to DONE with a zero result, products ignored.
    p_valid = 1'b1;
    p       = 32'd9;
    begin_block(8'd0);
    check("empty_ovalid", out_valid48, 1'b1);
    check("empty_acc", acc48, 48'h0);
    check("empty_ovf33", ovf33, 1'b0);
    check("empty_pready", p_ready48, 1'b0);
    tick();
    check("empty_acc_hold", acc48, 48'h0);
    p_valid = 1'b0;
    release_result();

    // Stalled result: stays put while OUT_READY is low; START is ignored.
    begin_block(8'd1);
    beat(32'd42);
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      len   = 8'd5;
      tick();
      check("stall_ovalid", out_valid48, 1'b1);
      check("stall_acc", acc48, 48'd42);
    end
    start = 1'b0;
    // START together with the release is not a new block.
    start     = 1'b1;
    out_ready = 1'b1;
    tick();
    start     = 1'b0;
    out_ready = 1'b0;
    check("rel_start_busy", busy48, 1'b0);
    check("rel_start_ovalid", out_valid48, 1'b0);
    tick();
    check("rel_start_idle", busy48, 1'b0);

    // Reset mid-block, with P_VALID asserted at the same edge.
    begin_block(8'd4);
    beat(32'd3);
    beat(32'd4);
    check("abort_acc_part", acc48, 48'd7);
    sclr    = 1'b1;
    p_valid = 1'b1;
    p       = 32'd100;
    tick();
    sclr    = 1'b0;
    p_valid = 1'b0;
    check("abort_busy", busy48, 1'b0);
    check("abort_acc", acc48, 48'h0);
    check("abort_pready", p_ready48, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("abort_no_ovalid", out_valid48, 1'b0);
    end

    // Maximum block length, no counter wrap.
    begin_block(8'd255);
    for (int i = 0; i < 254; i++) beat(32'd1);
    check("max_notdone", out_valid48, 1'b0);
    check("max_busy", busy48, 1'b1);
    beat(32'd1);
    check("max_ovalid", out_valid48, 1'b1);
    check("max_acc", acc48, 48'd255);
    release_result();
    check("max_idle", busy48, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_acc.md
MULT_ACC -- requirements
Module: mult_acc

Interface
REQ-001 Parameter ACC_W, default 48, accumulator width in bits; legal range 33..64.
REQ-002 Parameter LEN_W, default 8, width of the block-length field.
REQ-003 CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 SCLR  input  1  reset, synchronous and active-high.
REQ-005 START  input  1  begin a new accumulation block; sampled only in IDLE.
REQ-006 LEN  input  LEN_W  number of products in the block; sampled with START.
REQ-007 P  input  32  unsigned product from the upstream multiplier.
REQ-008 P_VALID  input  1  P holds a valid product this cycle.
REQ-009 P_READY  output  1  block accepts P this cycle.
REQ-010 ACC  output  ACC_W  accumulated sum.
REQ-011 OVF  output  1  sticky carry out of ACC_W during the current block.
REQ-012 OUT_VALID  output  1  ACC and OVF hold the final result of a block.
REQ-013 OUT_READY  input  1  downstream consumes the result.
REQ-014 BUSY  output  1  block is not in IDLE.

Function
REQ-015 FSM states: IDLE, ACCUM, DONE; encoding is free; BUSY=1 in ACCUM and DONE.
REQ-016 IDLE: P_READY=0, OUT_VALID=0; ACC and OVF keep the previous block's values.
REQ-017 IDLE and START=1, LEN!=0: latch LEN, ACC<=0, OVF<=0, beat counter<=0, next state ACCUM.
REQ-018 IDLE and START=1, LEN=0: ACC<=0, OVF<=0, next state DONE (empty block; result 0).
REQ-019 START outside IDLE is ignored and does not affect LEN or the counter.
REQ-020 ACCUM: P_READY=1 combinationally for every cycle spent in ACCUM.
REQ-021 Beat accepted when P_VALID=1 and P_READY=1: ACC<=ACC+zero-extended P, modulo 2^ACC_W.
REQ-022 Accepted beat with carry out of bit ACC_W-1: OVF<=1; OVF stays set until the next START or SCLR.
REQ-023 Cycles with P_VALID=0 in ACCUM leave ACC, OVF and the counter unchanged (bubbles allowed).
REQ-024 Counter increments once per accepted beat; the beat that makes count equal to the latched LEN moves FSM to DONE the next cycle.
REQ-025 Latency: ACC reflects an accepted beat in the cycle after acceptance; OUT_VALID rises the cycle after the last beat.
REQ-026 DONE: OUT_VALID=1, P_READY=0; ACC and OVF stable while OUT_VALID=1.
REQ-027 DONE and OUT_READY=1: next state IDLE; OUT_VALID drops the following cycle.
REQ-028 START asserted in the same cycle as DONE&OUT_READY is ignored; a new block needs START while in IDLE.
REQ-029 LEN=2^LEN_W-1 is supported with no counter wrap.
REQ-030 Products are unsigned; no signed interpretation anywhere.

Reset
REQ-031 SCLR=1 on a clock edge: state<=IDLE, ACC<=0, OVF<=0, counter<=0, latched LEN<=0.
REQ-032 Outputs after reset: P_READY=0, OUT_VALID=0, BUSY=0, ACC=0, OVF=0.
REQ-033 SCLR has priority over START, P_VALID and OUT_READY in the same cycle.
REQ-034 SCLR during ACCUM or DONE discards the partial or pending result; no OUT_VALID pulse follows.

Verification
REQ-035 START, LEN=3; P=5,7,11 back-to-back -> OUT_VALID one cycle after the third beat, ACC=23, OVF=0.
REQ-036 LEN=4 with P_VALID gaps of 0,2,1 idle cycles between beats, P=1 each -> ACC=4; P_READY high throughout ACCUM.
REQ-037 ACC_W=33, LEN=3, P=32'hFFFFFFFF each -> ACC=33'h0_FFFF_FFFD (wrap), OVF=1.
REQ-038 START with LEN=0 -> DONE next cycle, ACC=0, OVF=0, no P accepted.
REQ-039 OUT_READY held low 5 cycles in DONE -> ACC and OUT_VALID stable; START pulsed meanwhile is ignored.
REQ-040 SCLR after the 2nd of 4 beats -> next cycle IDLE, ACC=0, BUSY=0; no OUT_VALID.
